// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and the decode/execute/IR side.
// The sequencer owns the master modport; the consumers own the slave modport.
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESS_WIDTH = 3,
    parameter int unsigned CNT_WIDTH     = 8
);
    // feedback from the decode/execute stages
    logic                     halt;
    logic                     branch_taken;
    logic [ADDRESS_WIDTH-1:0] branch_target;
    logic                     stall;
    logic                     step;

    // sequencer outputs
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     ir_write;
    logic                     decode_en;
    logic                     exec_en;
    logic                     halted;
    logic [CNT_WIDTH-1:0]     retire_cnt;

    modport master (
        input  halt,
        input  branch_taken,
        input  branch_target,
        input  stall,
        input  step,
        output pc,
        output ir_write,
        output decode_en,
        output exec_en,
        output halted,
        output retire_cnt
    );

    modport slave (
        output halt,
        output branch_taken,
        output branch_target,
        output stall,
        output step,
        input  pc,
        input  ir_write,
        input  decode_en,
        input  exec_en,
        input  halted,
        input  retire_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: holds the PC and walks every instruction
// through FETCH -> DECODE -> EXECUTE, with halt and branch feedback.
// Optional single-step mode: define FETCH_SEQ_SINGLE_STEP_EN to park in
// STEP_WAIT after each EXECUTE until a step pulse arrives.
module fetch_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 3,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned CW = CNT_WIDTH;

    typedef enum logic [2:0] {
        S_BOOT      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_HALTED    = 3'd4
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 3'd5
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   retire_cnt_q, retire_cnt_d;
    logic            ir_write_q, ir_write_d;
    logic            decode_en_q, decode_en_d;
    logic            exec_en_q, exec_en_d;
    logic            halted_q, halted_d;

    // Branch targets are forced even; bit 0 is deliberately dropped.
    logic [AW-1:0]   branch_pc_c;
    logic            unused_c;

    assign branch_pc_c = {bus.branch_target[AW-1:1], 1'b0};
    assign unused_c    = ^{bus.step, bus.branch_target[0]};

    // State, PC, counter and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= '0;
            retire_cnt_q <= '0;
            ir_write_q   <= 1'b0;
            decode_en_q  <= 1'b0;
            exec_en_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            retire_cnt_q <= retire_cnt_d;
            ir_write_q   <= ir_write_d;
            decode_en_q  <= decode_en_d;
            exec_en_q    <= exec_en_d;
            halted_q     <= halted_d;
        end
    end

    // Next state, PC advance and retirement on EXECUTE exit
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        retire_cnt_d = retire_cnt_q;
        unique case (state_q)
            S_BOOT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = bus.halt ? S_HALTED : S_EXECUTE;
            S_EXECUTE: begin
                if (!bus.stall) begin
                    pc_d         = bus.branch_taken ? branch_pc_c : pc_q + AW'(2);
                    retire_cnt_d = retire_cnt_q + CW'(1);
`ifdef FETCH_SEQ_SINGLE_STEP_EN
                    state_d      = S_STEP_WAIT;
`else
                    state_d      = S_FETCH;
`endif
                end
            end
            S_HALTED: state_d = S_HALTED;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (bus.step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default:  state_d = S_BOOT;
        endcase
    end

    // Strobes decoded from the next state so the registered copies track state_q
    always_comb begin
        ir_write_d  = 1'b0;
        decode_en_d = 1'b0;
        exec_en_d   = 1'b0;
        halted_d    = 1'b0;
        unique case (state_d)
            S_FETCH:   ir_write_d  = 1'b1;
            S_DECODE:  decode_en_d = 1'b1;
            S_EXECUTE: exec_en_d   = 1'b1;
            S_HALTED:  halted_d    = 1'b1;
            default:   ;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.ir_write   = ir_write_q;
    assign bus.decode_en  = decode_en_q;
    assign bus.exec_en    = exec_en_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, normal sequencing, stall,
// branch, halt, ignored inputs, counter wrap, reset mid-stall, and the
// single-step mode when FETCH_SEQ_SINGLE_STEP_EN is defined.
module tb_fetch_sequencer;

    localparam int unsigned AW = 3;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_sequencer_if #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    fetch_sequencer #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.halt          = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.stall         = 1'b0;
        bus.step          = 1'b0;
    endtask

    // hold reset 3 cycles, release; afterwards the DUT sits in BOOT (cycle 0)
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.pc !== 3'd0) begin
            n_errors++; $display("FAIL reset_pc got=%0d want=0", bus.pc);
        end
        n_checks++;
        if (bus.retire_cnt !== 8'd0) begin
            n_errors++; $display("FAIL reset_cnt got=%0d want=0", bus.retire_cnt);
        end
        n_checks++;
        if ({bus.ir_write, bus.decode_en, bus.exec_en, bus.halted} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {bus.ir_write, bus.decode_en, bus.exec_en, bus.halted});
        end
    endtask

    task automatic test_sequence();
        logic [AW-1:0] exp_pc;
        logic [CW-1:0] exp_cnt;
        int idx;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            cyc();
            idx     = (c - 1) / 3;
            exp_pc  = AW'((2 * idx) % 8);
            exp_cnt = CW'(idx);
            n_checks++;
            if ({bus.ir_write, bus.decode_en, bus.exec_en} !==
                {(c % 3 == 1), (c % 3 == 2), (c % 3 == 0)}) begin
                n_errors++;
                $display("FAIL seq_strobes cyc=%0d got=%b%b%b", c,
                         bus.ir_write, bus.decode_en, bus.exec_en);
            end
            n_checks++;
            if (bus.pc !== exp_pc) begin
                n_errors++; $display("FAIL seq_pc cyc=%0d got=%0d want=%0d", c, bus.pc, exp_pc);
            end
            n_checks++;
            if (bus.retire_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL seq_cnt cyc=%0d got=%0d want=%0d", c, bus.retire_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc();                // FETCH
        cyc();                // DECODE
        bus.stall = 1'b1;     // ignored here, held into EXECUTE
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.exec_en !== 1'b1 || bus.pc !== 3'd0 || bus.retire_cnt !== 8'd0) begin
                n_errors++;
                $display("FAIL stall_hold i=%0d exec_en=%b pc=%0d cnt=%0d want 1/0/0",
                         i, bus.exec_en, bus.pc, bus.retire_cnt);
            end
            if (i == 3) bus.stall = 1'b0;
        end
        cyc();
        n_checks++;
        if (bus.ir_write !== 1'b1 || bus.pc !== 3'd2 || bus.retire_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL stall_exit ir_write=%b pc=%0d cnt=%0d want 1/2/1",
                     bus.ir_write, bus.pc, bus.retire_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (5) cyc();     // c5: DECODE at pc=2
        cyc();                // c6: EXECUTE
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'b101;
        cyc();                // c7: FETCH
        n_checks++;
        if (bus.pc !== 3'd4 || bus.ir_write !== 1'b1) begin
            n_errors++;
            $display("FAIL branch_odd pc=%0d ir_write=%b want 4/1", bus.pc, bus.ir_write);
        end
        bus.branch_target = 3'd0;   // not sampled outside EXECUTE
        cyc();                // c8: DECODE
        bus.branch_target = 3'd6;
        cyc();                // c9: EXECUTE
        cyc();                // c10: FETCH
        n_checks++;
        if (bus.pc !== 3'd6 || bus.retire_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL branch_even pc=%0d cnt=%0d want 6/3", bus.pc, bus.retire_cnt);
        end
        cyc();                // c11: DECODE
        bus.stall         = 1'b1;
        bus.branch_target = 3'd0;
        cyc();                // c12: EXECUTE, stalled
        cyc();                // c13: still EXECUTE
        n_checks++;
        if (bus.exec_en !== 1'b1 || bus.pc !== 3'd6 || bus.retire_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL branch_deferred exec_en=%b pc=%0d cnt=%0d want 1/6/3",
                     bus.exec_en, bus.pc, bus.retire_cnt);
        end
        bus.stall         = 1'b0;
        bus.branch_target = 3'd3;
        cyc();                // c14: FETCH
        n_checks++;
        if (bus.pc !== 3'd2 || bus.retire_cnt !== 8'd4 || bus.ir_write !== 1'b1) begin
            n_errors++;
            $display("FAIL branch_resample pc=%0d cnt=%0d ir_write=%b want 2/4/1",
                     bus.pc, bus.retire_cnt, bus.ir_write);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        repeat (4) cyc();     // c4: FETCH at pc=2
        bus.halt = 1'b1;      // ignored in FETCH
        cyc();                // c5: DECODE
        n_checks++;
        if (bus.decode_en !== 1'b1) begin
            n_errors++; $display("FAIL halt_decode decode_en=%b want 1", bus.decode_en);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd6;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) bus.halt = 1'b0;
            n_checks++;
            if (bus.halted !== 1'b1 || bus.pc !== 3'd2 || bus.retire_cnt !== 8'd1 ||
                {bus.ir_write, bus.decode_en, bus.exec_en} !== 3'b000) begin
                n_errors++;
                $display("FAIL halt_frozen i=%0d halted=%b pc=%0d cnt=%0d strobes=%b%b%b",
                         i, bus.halted, bus.pc, bus.retire_cnt,
                         bus.ir_write, bus.decode_en, bus.exec_en);
            end
        end
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if (bus.halted !== 1'b0 || bus.pc !== 3'd0 || bus.retire_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL halt_reset halted=%b pc=%0d cnt=%0d want 0/0/0",
                     bus.halted, bus.pc, bus.retire_cnt);
        end
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (bus.ir_write !== 1'b1) begin
            n_errors++; $display("FAIL halt_restart ir_write=%b want 1", bus.ir_write);
        end
    endtask

    task automatic test_halt_ignored();
        logic [AW-1:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            // current cycle is c-1; assert halt unless that cycle is DECODE
            bus.halt = ((c - 1) % 3 != 2) && (c != 1);
            cyc();
            exp_pc = AW'((2 * ((c - 1) / 3)) % 8);
            n_checks++;
            if (bus.halted !== 1'b0 || bus.pc !== exp_pc) begin
                n_errors++;
                $display("FAIL halt_ignored cyc=%0d halted=%b pc=%0d want 0/%0d",
                         c, bus.halted, bus.pc, exp_pc);
            end
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (766) cyc();   // FETCH of instruction 255
        n_checks++;
        if (bus.retire_cnt !== 8'd255 || bus.pc !== 3'd6 || bus.ir_write !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_pre cnt=%0d pc=%0d ir_write=%b want 255/6/1",
                     bus.retire_cnt, bus.pc, bus.ir_write);
        end
        repeat (3) cyc();
        n_checks++;
        if (bus.retire_cnt !== 8'd0 || bus.pc !== 3'd0 || bus.ir_write !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_post cnt=%0d pc=%0d ir_write=%b want 0/0/1",
                     bus.retire_cnt, bus.pc, bus.ir_write);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        repeat (5) cyc();     // c5: DECODE at pc=2, cnt=1
        bus.stall = 1'b1;
        repeat (3) cyc();     // stalled EXECUTE
        n_checks++;
        if (bus.exec_en !== 1'b1 || bus.pc !== 3'd2 || bus.retire_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL midstall_pre exec_en=%b pc=%0d cnt=%0d want 1/2/1",
                     bus.exec_en, bus.pc, bus.retire_cnt);
        end
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if (bus.exec_en !== 1'b0 || bus.pc !== 3'd0 || bus.retire_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL midstall_reset exec_en=%b pc=%0d cnt=%0d want 0/0/0",
                     bus.exec_en, bus.pc, bus.retire_cnt);
        end
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (bus.ir_write !== 1'b1 || bus.pc !== 3'd0) begin
            n_errors++;
            $display("FAIL midstall_restart ir_write=%b pc=%0d want 1/0", bus.ir_write, bus.pc);
        end
        clear_inputs();
    endtask

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset();
        repeat (3) cyc();     // c3: EXECUTE
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if ({bus.ir_write, bus.decode_en, bus.exec_en, bus.halted} !== 4'b0000 ||
                bus.pc !== 3'd2 || bus.retire_cnt !== 8'd1) begin
                n_errors++;
                $display("FAIL step_wait i=%0d strobes=%b%b%b%b pc=%0d cnt=%0d", i,
                         bus.ir_write, bus.decode_en, bus.exec_en, bus.halted,
                         bus.pc, bus.retire_cnt);
            end
        end
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        n_checks++;
        if (bus.ir_write !== 1'b1 || bus.pc !== 3'd2) begin
            n_errors++;
            $display("FAIL step_go ir_write=%b pc=%0d want 1/2", bus.ir_write, bus.pc);
        end
        repeat (3) cyc();     // DECODE, EXECUTE, STEP_WAIT
        n_checks++;
        if (bus.ir_write !== 1'b0 || bus.pc !== 3'd4 || bus.retire_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL step_wait2 ir_write=%b pc=%0d cnt=%0d want 0/4/2",
                     bus.ir_write, bus.pc, bus.retire_cnt);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_checks++;
        if (bus.pc !== 3'd0 || bus.retire_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL step_reset pc=%0d cnt=%0d want 0/0", bus.pc, bus.retire_cnt);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        test_single_step();
`else
        test_sequence();
        test_stall();
        test_branch();
        test_halt();
        test_halt_ignored();
        test_wrap();
        test_reset_mid_stall();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
